// File: rtl/multi_cycle_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module   : multi_cycle_ctrl_pkg
// Purpose  : Shared definitions for the multi-cycle MIPS-style controller.
//            Contents: FSM state encoding, latched instruction-class encoding,
//            ALU operation codes, immediate-extension codes, datapath select
//            codes and the opcode/funct constants recognised by the decoder.
// Revision : 1.0 - initial release
// ============================================================================
package multi_cycle_ctrl_pkg;

   // FSM states; the encoding is visible on the controller's state port.
   typedef enum logic [2:0] {
      ST_IF  = 3'd0,
      ST_ID  = 3'd1,
      ST_EX  = 3'd2,
      ST_MEM = 3'd3,
      ST_WB  = 3'd4
   } state_t;

   // Instruction class latched at the end of ID.
   typedef enum logic [3:0] {
      CL_RTYPE   = 4'd0,
      CL_ORI     = 4'd1,
      CL_LUI     = 4'd2,
      CL_SLTI    = 4'd3,
      CL_LW      = 4'd4,
      CL_SW      = 4'd5,
      CL_BEQ     = 4'd6,
      CL_BNE     = 4'd7,
      CL_J       = 4'd8,
      CL_ILLEGAL = 4'd9
   } instr_class_t;

   // ALU operation codes driven on Aluctrl.
   localparam logic [4:0] ALU_ADDU = 5'd0;
   localparam logic [4:0] ALU_SUBU = 5'd1;
   localparam logic [4:0] ALU_ADD  = 5'd2;
   localparam logic [4:0] ALU_SUB  = 5'd3;
   localparam logic [4:0] ALU_AND  = 5'd4;
   localparam logic [4:0] ALU_OR   = 5'd5;
   localparam logic [4:0] ALU_SLL  = 5'd6;
   localparam logic [4:0] ALU_SRL  = 5'd7;
   localparam logic [4:0] ALU_SLT  = 5'd8;
   localparam logic [4:0] ALU_EQL  = 5'd9;
   localparam logic [4:0] ALU_BNE  = 5'd10;

   // Immediate extension modes driven on ExtOp.
   localparam logic [1:0] EXT_ZERO    = 2'd0;
   localparam logic [1:0] EXT_SIGNED  = 2'd1;
   localparam logic [1:0] EXT_HIGHPOS = 2'd2;

   // ALU operand-B selects driven on AluSrcB.
   localparam logic [1:0] SRCB_REG    = 2'd0;   // rt register
   localparam logic [1:0] SRCB_FOUR   = 2'd1;   // constant 4 (PC increment)
   localparam logic [1:0] SRCB_IMM    = 2'd2;   // extended immediate
   localparam logic [1:0] SRCB_BRANCH = 2'd3;   // extended immediate << 2

   // PC source selects driven on PCSource.
   localparam logic [1:0] PCSRC_SEQ    = 2'd0;
   localparam logic [1:0] PCSRC_BRANCH = 2'd1;
   localparam logic [1:0] PCSRC_JUMP   = 2'd2;

   // Opcodes (IR[31:26]).
   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_J     = 6'b000010;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_BNE   = 6'b000101;
   localparam logic [5:0] OP_SLTI  = 6'b001010;
   localparam logic [5:0] OP_ORI   = 6'b001101;
   localparam logic [5:0] OP_LUI   = 6'b001111;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;

   // R-type function codes (IR[5:0]).
   localparam logic [5:0] FN_SLL  = 6'b000000;
   localparam logic [5:0] FN_SRL  = 6'b000010;
   localparam logic [5:0] FN_ADD  = 6'b100000;
   localparam logic [5:0] FN_ADDU = 6'b100001;
   localparam logic [5:0] FN_SUB  = 6'b100010;
   localparam logic [5:0] FN_SUBU = 6'b100011;
   localparam logic [5:0] FN_AND  = 6'b100100;
   localparam logic [5:0] FN_OR   = 6'b100101;
   localparam logic [5:0] FN_SLT  = 6'b101010;

endpackage
`default_nettype wire

// File: rtl/multi_cycle_ctrl_instr_class_dec.sv
`default_nettype none
// ============================================================================
// Module   : instr_class_dec
// Purpose  : Purely combinational opcode/funct decode into an instruction
//            class plus the ALU operation an R-type instruction needs in EX.
// Ports    : opcode    in  6  IR[31:26]
//            funct     in  6  IR[5:0]
//            cls       out    decoded instruction class (CL_ILLEGAL if unknown)
//            rtype_alu out 5  ALU op for R-type funct (ALU_ADDU otherwise)
// Revision : 1.0 - initial release
// ============================================================================
module instr_class_dec
   import multi_cycle_ctrl_pkg::*;
(
   input  logic [5:0]   opcode,
   input  logic [5:0]   funct,
   output instr_class_t cls,
   output logic [4:0]   rtype_alu
);

   always_comb begin
      cls       = CL_ILLEGAL;
      rtype_alu = ALU_ADDU;
      case (opcode)
         OP_RTYPE: begin
            cls = CL_RTYPE;
            case (funct)
               FN_ADDU: rtype_alu = ALU_ADDU;
               FN_SUBU: rtype_alu = ALU_SUBU;
               FN_ADD:  rtype_alu = ALU_ADD;
               FN_SUB:  rtype_alu = ALU_SUB;
               FN_AND:  rtype_alu = ALU_AND;
               FN_OR:   rtype_alu = ALU_OR;
               FN_SLL:  rtype_alu = ALU_SLL;
               FN_SRL:  rtype_alu = ALU_SRL;
               FN_SLT:  rtype_alu = ALU_SLT;
               // An R-type with an unknown funct is as undecodable as an
               // unknown opcode.
               default: cls = CL_ILLEGAL;
            endcase
         end
         OP_ORI:  cls = CL_ORI;
         OP_LUI:  cls = CL_LUI;
         OP_SLTI: cls = CL_SLTI;
         OP_LW:   cls = CL_LW;
         OP_SW:   cls = CL_SW;
         OP_BEQ:  cls = CL_BEQ;
         OP_BNE:  cls = CL_BNE;
         OP_J:    cls = CL_J;
         default: cls = CL_ILLEGAL;
      endcase
   end

endmodule
`default_nettype wire

// File: rtl/multi_cycle_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : multi_cycle_ctrl
// Purpose  : Five-state (IF/ID/EX/MEM/WB) control unit for a multi-cycle
//            MIPS-subset datapath. Outputs are decoded from the current state
//            and the instruction class latched in ID; IF/MEM additionally
//            react to mem_ready and EX branches to alu_zero.
// Config   : JUMP_EARLY_EN - when defined, J completes in ID (2 cycles)
//            instead of in EX (3 cycles).
// Params   : MEM_TIMEOUT - consecutive mem_ready=0 cycles tolerated in IF/MEM
//            before the access is aborted; 0 disables the abort.
// Ports    : clk, rst (sync, active-high); OpCode/funct instruction fields;
//            alu_zero, mem_ready status inputs; datapath strobes/selects
//            PCWrite IorD MemR MemW IRWrite RegDst Mem2R RegW AluSrcA
//            AluSrcB PCSource ExtOp Aluctrl; state (current FSM state);
//            illegal (1-cycle pulse, undecodable instruction in ID);
//            timeout (1-cycle pulse, memory access aborted).
// Revision : 1.0 - initial release
// ============================================================================
module multi_cycle_ctrl
   import multi_cycle_ctrl_pkg::*;
#(
   parameter int unsigned MEM_TIMEOUT = 0
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [5:0] OpCode,
   input  logic [5:0] funct,
   input  logic       alu_zero,
   input  logic       mem_ready,
   output logic       PCWrite,
   output logic       IorD,
   output logic       MemR,
   output logic       MemW,
   output logic       IRWrite,
   output logic       RegDst,
   output logic       Mem2R,
   output logic       RegW,
   output logic       AluSrcA,
   output logic [1:0] AluSrcB,
   output logic [1:0] PCSource,
   output logic [1:0] ExtOp,
   output logic [4:0] Aluctrl,
   output logic [2:0] state,
   output logic       illegal,
   output logic       timeout
);

   localparam int unsigned CNT_W = (MEM_TIMEOUT < 2) ? 1 : $clog2(MEM_TIMEOUT + 1);

   state_t       cur_state;
   state_t       nxt_state;
   instr_class_t cls_q;
   instr_class_t dec_cls;
   logic [4:0]   alu_q;
   logic [4:0]   dec_alu;
   logic         abort;

   // Strobes before the reset / abort qualification.
   logic pc_write_raw;
   logic ir_write_raw;
   logic mem_r_raw;
   logic mem_w_raw;
   logic reg_w_raw;
   logic illegal_raw;

   // The IR is only stable from ID onward, so the decode result is used
   // live in ID and otherwise only through the copy latched at ID exit.
   instr_class_dec u_dec (
      .opcode    (OpCode),
      .funct     (funct),
      .cls       (dec_cls),
      .rtype_alu (dec_alu)
   );

   // ------------------------------------------------------------------
   // Memory wait watchdog
   // ------------------------------------------------------------------
   generate
      if (MEM_TIMEOUT > 0) begin : g_timeout
         logic [CNT_W-1:0] wait_cnt;
         logic             mem_wait;

         assign mem_wait = ((cur_state == ST_IF) || (cur_state == ST_MEM)) && !mem_ready;
         // Fires on the MEM_TIMEOUT-th consecutive stalled cycle.
         assign abort    = mem_wait && (wait_cnt == CNT_W'(MEM_TIMEOUT - 1));

         // Any cycle that is not a continuing stall (ready, other state, or
         // the abort itself) restarts the count, so it never carries over
         // from one access to the next.
         always_ff @(posedge clk) begin
            if (rst || !mem_wait || abort) begin
               wait_cnt <= '0;
            end else begin
               wait_cnt <= wait_cnt + CNT_W'(1);
            end
         end
      end else begin : g_no_timeout
         assign abort = 1'b0;
      end
   endgenerate

   // ------------------------------------------------------------------
   // State and class registers
   // ------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (rst) begin
         cur_state <= ST_IF;
         cls_q     <= CL_RTYPE;
         alu_q     <= ALU_ADDU;
      end else begin
         cur_state <= nxt_state;
         if (cur_state == ST_ID) begin
            cls_q <= dec_cls;
            alu_q <= dec_alu;
         end
      end
   end

   // ------------------------------------------------------------------
   // Next-state and output decode
   // ------------------------------------------------------------------
   always_comb begin
      nxt_state    = cur_state;
      pc_write_raw = 1'b0;
      ir_write_raw = 1'b0;
      mem_r_raw    = 1'b0;
      mem_w_raw    = 1'b0;
      reg_w_raw    = 1'b0;
      illegal_raw  = 1'b0;
      IorD         = 1'b0;
      RegDst       = 1'b0;
      Mem2R        = 1'b0;
      AluSrcA      = 1'b0;
      AluSrcB      = SRCB_REG;
      PCSource     = PCSRC_SEQ;
      ExtOp        = EXT_ZERO;
      Aluctrl      = ALU_ADDU;

      case (cur_state)
         ST_IF: begin
            mem_r_raw = 1'b1;
            // The PC increment happens in the same cycle the fetch lands.
            if (mem_ready) begin
               ir_write_raw = 1'b1;
               pc_write_raw = 1'b1;
               PCSource     = PCSRC_SEQ;
               AluSrcB      = SRCB_FOUR;
               Aluctrl      = ALU_ADDU;
               nxt_state    = ST_ID;
            end
         end

         ST_ID: begin
            // Branch target PC + (sext(imm) << 2) is computed speculatively.
            AluSrcB = SRCB_BRANCH;
            ExtOp   = EXT_SIGNED;
            Aluctrl = ALU_ADD;
            case (dec_cls)
               CL_ILLEGAL: begin
                  illegal_raw = 1'b1;
                  nxt_state   = ST_IF;
               end
`ifdef JUMP_EARLY_EN
               CL_J: begin
                  PCSource     = PCSRC_JUMP;
                  pc_write_raw = 1'b1;
                  nxt_state    = ST_IF;
               end
`endif
               default: nxt_state = ST_EX;
            endcase
         end

         ST_EX: begin
            // Operand A is rs for every EX operation except the jump.
            AluSrcA   = 1'b1;
            nxt_state = ST_WB;
            case (cls_q)
               CL_RTYPE: begin
                  AluSrcB = SRCB_REG;
                  Aluctrl = alu_q;
               end
               CL_ORI: begin
                  AluSrcB = SRCB_IMM;
                  ExtOp   = EXT_ZERO;
                  Aluctrl = ALU_OR;
               end
               CL_LUI: begin
                  AluSrcB = SRCB_IMM;
                  ExtOp   = EXT_HIGHPOS;
                  Aluctrl = ALU_ADDU;
               end
               CL_SLTI: begin
                  AluSrcB = SRCB_IMM;
                  ExtOp   = EXT_SIGNED;
                  Aluctrl = ALU_SLT;
               end
               CL_LW, CL_SW: begin
                  AluSrcB   = SRCB_IMM;
                  ExtOp     = EXT_SIGNED;
                  Aluctrl   = ALU_ADD;
                  nxt_state = ST_MEM;
               end
               CL_BEQ, CL_BNE: begin
                  // The ALU raises alu_zero when the branch condition holds.
                  AluSrcB      = SRCB_REG;
                  Aluctrl      = (cls_q == CL_BEQ) ? ALU_EQL : ALU_BNE;
                  PCSource     = PCSRC_BRANCH;
                  pc_write_raw = alu_zero;
                  nxt_state    = ST_IF;
               end
               CL_J: begin
                  AluSrcA      = 1'b0;
                  PCSource     = PCSRC_JUMP;
                  pc_write_raw = 1'b1;
                  nxt_state    = ST_IF;
               end
               default: begin
                  AluSrcA   = 1'b0;
                  nxt_state = ST_IF;
               end
            endcase
         end

         ST_MEM: begin
            IorD      = 1'b1;
            mem_r_raw = (cls_q == CL_LW);
            mem_w_raw = (cls_q == CL_SW);
            if (abort) begin
               nxt_state = ST_IF;
            end else if (mem_ready) begin
               nxt_state = (cls_q == CL_LW) ? ST_WB : ST_IF;
            end
         end

         ST_WB: begin
            reg_w_raw = 1'b1;
            RegDst    = (cls_q == CL_RTYPE);
            Mem2R     = (cls_q == CL_LW);
            nxt_state = ST_IF;
         end

         default: nxt_state = ST_IF;
      endcase
   end

   // Reset kills every strobe immediately, even mid-instruction; an abort
   // cycle suppresses the architectural writes only.
   assign PCWrite = pc_write_raw & ~rst & ~abort;
   assign IRWrite = ir_write_raw & ~rst & ~abort;
   assign MemW    = mem_w_raw    & ~rst & ~abort;
   assign RegW    = reg_w_raw    & ~rst & ~abort;
   assign MemR    = mem_r_raw    & ~rst;
   assign illegal = illegal_raw  & ~rst;
   assign timeout = abort        & ~rst;
   assign state   = cur_state;

endmodule
`default_nettype wire

// File: tb/tb_multi_cycle_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_multi_cycle_ctrl
// Purpose  : Self-checking bench for multi_cycle_ctrl. Two controllers are
//            built, one without memory timeout and one with MEM_TIMEOUT=2.
//            A driver walks each instruction through its phases from the
//            instruction-level rules and queues the full expected output
//            vector per cycle; a monitor pops and compares on the falling
//            edge. Honours JUMP_EARLY_EN like the design.
// Revision : 1.0 - initial release
// ============================================================================
module tb_multi_cycle_ctrl;
   import multi_cycle_ctrl_pkg::*;

   localparam int unsigned TO_B = 2;
`ifdef JUMP_EARLY_EN
   localparam bit JEARLY = 1'b1;
`else
   localparam bit JEARLY = 1'b0;
`endif

   typedef struct packed {
      logic       pcwrite;
      logic       iord;
      logic       memr;
      logic       memw;
      logic       irwrite;
      logic       regdst;
      logic       mem2r;
      logic       regw;
      logic       srca;
      logic [1:0] srcb;
      logic [1:0] pcsrc;
      logic [1:0] extop;
      logic [4:0] aluctrl;
      logic [2:0] st;
      logic       illegal;
      logic       timeout;
   } out_t;

   logic       clk = 1'b0;
   always #5 clk = ~clk;

   logic       rst       [2];
   logic       mem_ready [2];
   logic       alu_zero  [2];
   logic [5:0] opc       [2];
   logic [5:0] fnc       [2];
   out_t       obs       [2];

   out_t q0[$];
   out_t q1[$];
   int   n_checks = 0;
   int   n_fail   = 0;

   // Reference instruction tables.
   logic [5:0]   op_tab  [9] = '{OP_RTYPE, OP_ORI, OP_LUI, OP_SLTI, OP_LW, OP_SW, OP_BEQ, OP_BNE, OP_J};
   instr_class_t cls_tab [9] = '{CL_RTYPE, CL_ORI, CL_LUI, CL_SLTI, CL_LW, CL_SW, CL_BEQ, CL_BNE, CL_J};
   logic [5:0]   fn_tab  [9] = '{FN_ADDU, FN_SUBU, FN_ADD, FN_SUB, FN_AND, FN_OR, FN_SLL, FN_SRL, FN_SLT};
   logic [4:0]   fal_tab [9] = '{ALU_ADDU, ALU_SUBU, ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_SLL, ALU_SRL, ALU_SLT};

   for (genvar k = 0; k < 2; k++) begin : g_dut
      logic       PCWrite, IorD, MemR, MemW, IRWrite, RegDst, Mem2R, RegW, AluSrcA;
      logic [1:0] AluSrcB, PCSource, ExtOp;
      logic [4:0] Aluctrl;
      logic [2:0] state;
      logic       illegal, timeout;

      multi_cycle_ctrl #(.MEM_TIMEOUT((k == 0) ? 0 : TO_B)) u_dut (
         .clk      (clk),
         .rst      (rst[k]),
         .OpCode   (opc[k]),
         .funct    (fnc[k]),
         .alu_zero (alu_zero[k]),
         .mem_ready(mem_ready[k]),
         .PCWrite  (PCWrite),
         .IorD     (IorD),
         .MemR     (MemR),
         .MemW     (MemW),
         .IRWrite  (IRWrite),
         .RegDst   (RegDst),
         .Mem2R    (Mem2R),
         .RegW     (RegW),
         .AluSrcA  (AluSrcA),
         .AluSrcB  (AluSrcB),
         .PCSource (PCSource),
         .ExtOp    (ExtOp),
         .Aluctrl  (Aluctrl),
         .state    (state),
         .illegal  (illegal),
         .timeout  (timeout)
      );

      assign obs[k] = {PCWrite, IorD, MemR, MemW, IRWrite, RegDst, Mem2R, RegW, AluSrcA,
                       AluSrcB, PCSource, ExtOp, Aluctrl, state, illegal, timeout};
   end

   // ---------------- reference model ----------------
   function automatic void ref_decode(input logic [5:0] op, input logic [5:0] f,
                                      output instr_class_t c, output logic [4:0] a);
      c = CL_ILLEGAL;
      a = ALU_ADDU;
      for (int i = 0; i < 9; i++) if (op_tab[i] == op) c = cls_tab[i];
      if (c == CL_RTYPE) begin
         c = CL_ILLEGAL;
         for (int i = 0; i < 9; i++) begin
            if (fn_tab[i] == f) begin
               c = CL_RTYPE;
               a = fal_tab[i];
            end
         end
      end
   endfunction

   function automatic out_t exp_base(input state_t s);
      out_t e;
      e    = '0;
      e.st = s;
      return e;
   endfunction

   function automatic out_t exp_if(input logic mr, input bit ab, input bit in_rst);
      out_t e;
      e      = exp_base(ST_IF);
      e.memr = !in_rst;
      if (mr) begin
         e.irwrite = !in_rst;
         e.pcwrite = !in_rst;
         e.srcb    = SRCB_FOUR;
         e.aluctrl = ALU_ADDU;
      end
      e.timeout = ab;
      return e;
   endfunction

   function automatic out_t exp_id(input instr_class_t c);
      out_t e;
      e         = exp_base(ST_ID);
      e.srcb    = SRCB_BRANCH;
      e.extop   = EXT_SIGNED;
      e.aluctrl = ALU_ADD;
      e.illegal = (c == CL_ILLEGAL);
      if (JEARLY && c == CL_J) begin
         e.pcwrite = 1'b1;
         e.pcsrc   = PCSRC_JUMP;
      end
      return e;
   endfunction

   function automatic out_t exp_ex(input instr_class_t c, input logic [4:0] a, input logic az);
      out_t e;
      e      = exp_base(ST_EX);
      e.srca = 1'b1;
      case (c)
         CL_RTYPE: e.aluctrl = a;
         CL_ORI:   begin e.srcb = SRCB_IMM; e.extop = EXT_ZERO;    e.aluctrl = ALU_OR;   end
         CL_LUI:   begin e.srcb = SRCB_IMM; e.extop = EXT_HIGHPOS; e.aluctrl = ALU_ADDU; end
         CL_SLTI:  begin e.srcb = SRCB_IMM; e.extop = EXT_SIGNED;  e.aluctrl = ALU_SLT;  end
         CL_LW,
         CL_SW:    begin e.srcb = SRCB_IMM; e.extop = EXT_SIGNED;  e.aluctrl = ALU_ADD;  end
         CL_BEQ:   begin e.aluctrl = ALU_EQL; e.pcsrc = PCSRC_BRANCH; e.pcwrite = az; end
         CL_BNE:   begin e.aluctrl = ALU_BNE; e.pcsrc = PCSRC_BRANCH; e.pcwrite = az; end
         CL_J:     begin e.srca = 1'b0; e.pcsrc = PCSRC_JUMP; e.pcwrite = 1'b1; end
         default:  e.srca = 1'b0;
      endcase
      return e;
   endfunction

   function automatic out_t exp_mem(input instr_class_t c, input bit ab, input bit in_rst);
      out_t e;
      e         = exp_base(ST_MEM);
      e.iord    = 1'b1;
      e.memr    = (c == CL_LW) && !in_rst;
      e.memw    = (c == CL_SW) && !in_rst && !ab;
      e.timeout = ab;
      return e;
   endfunction

   function automatic out_t exp_wb(input instr_class_t c);
      out_t e;
      e        = exp_base(ST_WB);
      e.regw   = 1'b1;
      e.regdst = (c == CL_RTYPE);
      e.mem2r  = (c == CL_LW);
      return e;
   endfunction

   // ---------------- driver ----------------
   task automatic cyc(input int k, input logic rs, input logic mr, input logic az, input out_t e);
      rst[k]       = rs;
      mem_ready[k] = mr;
      alu_zero[k]  = az;
      if (k == 0) q0.push_back(e);
      else        q1.push_back(e);
      @(posedge clk);
      #1;
   endtask

   task automatic run_instr(input int k, input int to, input logic [5:0] op, input logic [5:0] f,
                            input int w_if, input int w_mem, input logic az, input bit rst_in_mem);
      instr_class_t c;
      logic [4:0]   a;
      bit           ab;
      ref_decode(op, f, c, a);
      opc[k] = op;
      fnc[k] = f;
      for (int i = 0; i < w_if; i++) begin
         ab = (to > 0) && (i == to - 1);
         cyc(k, 1'b0, 1'b0, 1'($urandom), exp_if(1'b0, ab, 1'b0));
         if (ab) return;
      end
      cyc(k, 1'b0, 1'b1, 1'($urandom), exp_if(1'b1, 1'b0, 1'b0));
      cyc(k, 1'b0, 1'($urandom), 1'($urandom), exp_id(c));
      if (c == CL_ILLEGAL || (JEARLY && c == CL_J)) return;
      cyc(k, 1'b0, 1'($urandom), az, exp_ex(c, a, az));
      if (c == CL_LW || c == CL_SW) begin
         if (rst_in_mem) begin
            cyc(k, 1'b1, 1'b0, 1'($urandom), exp_mem(c, 1'b0, 1'b1));
            return;
         end
         for (int i = 0; i < w_mem; i++) begin
            ab = (to > 0) && (i == to - 1);
            cyc(k, 1'b0, 1'b0, 1'($urandom), exp_mem(c, ab, 1'b0));
            if (ab) return;
         end
         cyc(k, 1'b0, 1'b1, 1'($urandom), exp_mem(c, 1'b0, 1'b0));
         if (c == CL_SW) return;
      end else if (c == CL_BEQ || c == CL_BNE || c == CL_J) begin
         return;
      end
      cyc(k, 1'b0, 1'($urandom), 1'($urandom), exp_wb(c));
   endtask

   task automatic rand_instr(input int k, input int to);
      logic [5:0] op;
      logic [5:0] f;
      int unsigned sel;
      sel = $urandom_range(0, 10);
      if (sel < 9) op = op_tab[sel];
      else         op = 6'($urandom);
      if ($urandom_range(0, 3) == 0) f = 6'($urandom);
      else                           f = fn_tab[$urandom_range(0, 8)];
      run_instr(k, to, op, f, int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                1'($urandom), ($urandom_range(0, 29) == 0));
   endtask

   // ---------------- monitor ----------------
   function automatic void check(input int k, input out_t e);
      n_checks++;
      if (obs[k] !== e) begin
         n_fail++;
         $display("FAIL dut%0d outputs @%0t: actual=%h (state %0d) required=%h (state %0d)",
                  k, $time, obs[k], obs[k].st, e, e.st);
      end
   endfunction

   always @(negedge clk) begin
      if (q0.size() > 0) check(0, q0.pop_front());
      if (q1.size() > 0) check(1, q1.pop_front());
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // ---------------- stimulus ----------------
   initial begin
      for (int k = 0; k < 2; k++) begin
         rst[k] = 1'b1; mem_ready[k] = 1'b0; alu_zero[k] = 1'b0;
         opc[k] = 6'd0; fnc[k] = 6'd0;
      end
      @(posedge clk);
      #1;

      // Controller without timeout: reset, directed cases, then random.
      cyc(0, 1'b1, 1'b0, 1'b0, exp_if(1'b0, 1'b0, 1'b1));
      cyc(0, 1'b1, 1'b1, 1'b0, exp_if(1'b1, 1'b0, 1'b1));
      run_instr(0, 0, OP_LW,    6'h15,   0, 0, 1'b0, 1'b0);
      run_instr(0, 0, OP_BEQ,   6'h00,   0, 0, 1'b1, 1'b0);
      run_instr(0, 0, OP_BEQ,   6'h00,   0, 0, 1'b0, 1'b0);
      run_instr(0, 0, OP_BNE,   6'h00,   0, 0, 1'b1, 1'b0);
      run_instr(0, 0, OP_BNE,   6'h00,   0, 0, 1'b0, 1'b0);
      run_instr(0, 0, OP_RTYPE, FN_ADDU, 3, 0, 1'b0, 1'b0);
      run_instr(0, 0, OP_RTYPE, 6'h3F,   0, 0, 1'b0, 1'b0);
      run_instr(0, 0, OP_SW,    6'h00,   0, 2, 1'b0, 1'b1);
      run_instr(0, 0, OP_J,     6'h00,   0, 0, 1'b0, 1'b0);
      run_instr(0, 0, OP_ORI,   6'h00,   0, 0, 1'b0, 1'b0);
      run_instr(0, 0, OP_LUI,   6'h00,   1, 0, 1'b0, 1'b0);
      run_instr(0, 0, OP_SLTI,  6'h00,   0, 0, 1'b0, 1'b0);
      run_instr(0, 0, OP_SW,    6'h00,   0, 2, 1'b0, 1'b0);
      run_instr(0, 0, OP_LW,    6'h00,   2, 3, 1'b0, 1'b0);
      run_instr(0, 0, OP_RTYPE, FN_SLT,  0, 0, 1'b0, 1'b0);
      run_instr(0, 0, 6'b111111, 6'h00,  0, 0, 1'b0, 1'b0);
      repeat (150) rand_instr(0, 0);
      rst[0] = 1'b1;

      // Controller with MEM_TIMEOUT=2.
      cyc(1, 1'b1, 1'b0, 1'b0, exp_if(1'b0, 1'b0, 1'b1));
      run_instr(1, TO_B, OP_RTYPE, FN_OR,  2, 0, 1'b0, 1'b0);
      run_instr(1, TO_B, OP_RTYPE, FN_OR,  1, 0, 1'b0, 1'b0);
      run_instr(1, TO_B, OP_SW,    6'h00,  0, 2, 1'b0, 1'b0);
      run_instr(1, TO_B, OP_LW,    6'h00,  0, 3, 1'b0, 1'b0);
      run_instr(1, TO_B, OP_LW,    6'h00,  1, 1, 1'b0, 1'b0);
      run_instr(1, TO_B, OP_SW,    6'h00,  3, 0, 1'b0, 1'b0);
      repeat (150) rand_instr(1, TO_B);

      @(posedge clk);
      #1;
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
